i2s_tx_fifo: RTL

Parametrised stereo I2S/PCM serial transmitter with an input sample FIFO, for PCM5102-class DACs. It sits between the NCO/sample source and the DAC pins. It accepts left/right sample pairs over a valid/ready handshake, buffers them, and serialises them as BCK/LRCK/DIN. The block supports selectable frame format, mute, and underrun detection.

---
 rtl/i2s_tx_fifo_if.sv | 17 +
 rtl/i2s_tx_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_fifo_if.sv
// Sample-pair handshake between the sample source and the I2S transmitter.
//   s_valid : source has a left/right pair on s_left/s_right
//   s_ready : transmitter FIFO can take a pair this cycle
//   s_left  : left sample, two's complement
//   s_right : right sample, two's complement
// master = sample source, slave = transmitter.
interface i2s_tx_fifo_if #(
   parameter int unsigned DAC_WIDTH = 16
);
   logic                 s_valid;
   logic                 s_ready;
   logic [DAC_WIDTH-1:0] s_left;
   logic [DAC_WIDTH-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_fifo.sv
// Stereo I2S / left-justified / right-justified serial transmitter with a small
// input FIFO of left/right sample pairs. Serialises onto BCK/LRCK/DIN for
// PCM5102-class DACs.
//   clk          : system clock, all logic and outputs in this domain
//   arst         : asynchronous active-low reset
//   fmt          : 0 I2S, 1 left-justified, 2 right-justified, 3 I2S; latched at frame start
//   mute         : frame loaded at the next frame start carries zeros (FIFO still pops)
//   s            : sample-pair valid/ready handshake (slave side)
//   bck          : bit clock
//   lrck         : word select
//   din          : serial data, MSB first
//   frame_strobe : one-clk pulse at each frame start
//   underrun     : one-clk pulse at a frame start that found the FIFO empty
//   fifo_level   : occupied FIFO entries
module i2s_tx_fifo #(
   parameter int unsigned DAC_WIDTH  = 16,
   parameter int unsigned SLOT_WIDTH = 32,
   parameter int unsigned BCK_HALF   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            arst,
   input  logic [1:0]                      fmt,
   input  logic                            mute,
   i2s_tx_fifo_if.slave                    s,
   output logic                            bck,
   output logic                            lrck,
   output logic                            din,
   output logic                            frame_strobe,
   output logic                            underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
   localparam int unsigned DivW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
   localparam int unsigned BW   = $clog2(2 * SLOT_WIDTH);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned LW   = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] FMT_LJ = 2'd1;
   localparam logic [1:0] FMT_RJ = 2'd2;

   localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_WIDTH - 1);

   // ---------------------------------------------------------------- bit clock
   logic [DivW-1:0] div_q;
   logic            bck_q;
   logic            div_wrap;
   logic            fall;

   assign div_wrap = (div_q == DivW'(BCK_HALF - 1));
   assign fall     = div_wrap & bck_q;

   // ---------------------------------------------------------------- frame state
   logic [BW-1:0]        b_q;
   logic [1:0]           fmt_q;
   logic [DAC_WIDTH-1:0] left_q, right_q;
   logic                 lrck_q, din_q, fs_q, und_q;
   logic                 frame_start;

   assign frame_start = fall && (b_q == LAST_BIT);

   // ---------------------------------------------------------------- FIFO
   logic [2*DAC_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]            wptr_q, rptr_q, wptr_d, rptr_d;
   logic                   ready_q, ready_d;
   logic                   empty, push, pop;
   logic [2*DAC_WIDTH-1:0] head;

   assign empty = (wptr_q == rptr_q);
   assign push  = s.s_valid && ready_q;
   // An entry pushed in the frame-start cycle is not yet visible to that pop.
   assign pop   = frame_start && !empty;
   assign head  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d  = push ? wptr_q + (AW+1)'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
      // Ready is the registered complement of next-cycle full.
      ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= {s.s_left, s.s_right};
      end
   end

   // ---------------------------------------------------------------- serialiser
   logic [DAC_WIDTH-1:0] load_l, load_r, left_eff, right_eff, word, word_sh;
   logic [BW-1:0]        b_nxt, p_nxt, start, off;
   logic [1:0]           fmt_eff;
   logic                 right_slot, left_high, lrck_d, din_d;

   assign load_l = (empty || mute) ? '0 : head[2*DAC_WIDTH-1:DAC_WIDTH];
   assign load_r = (empty || mute) ? '0 : head[DAC_WIDTH-1:0];

   // Output bits are computed for the position the next falling edge moves to, using
   // the data and format being loaded when that edge is also the frame start.
   always_comb begin
      b_nxt      = (b_q == LAST_BIT) ? '0 : b_q + BW'(1);
      right_slot = (b_nxt >= BW'(SLOT_WIDTH));
      p_nxt      = right_slot ? b_nxt - BW'(SLOT_WIDTH) : b_nxt;
      fmt_eff    = frame_start ? fmt : fmt_q;
      left_eff   = frame_start ? load_l : left_q;
      right_eff  = frame_start ? load_r : right_q;
      start      = BW'(1);
      left_high  = 1'b0;
      case (fmt_eff)
         FMT_LJ: begin
            start     = '0;
            left_high = 1'b1;
         end
         FMT_RJ: begin
            start     = BW'(SLOT_WIDTH - DAC_WIDTH);
            left_high = 1'b1;
         end
         default: begin
            start     = BW'(1);
            left_high = 1'b0;
         end
      endcase
      off     = p_nxt - start;
      word    = right_slot ? right_eff : left_eff;
      word_sh = word << off;
      din_d   = (p_nxt >= start) && (off < BW'(DAC_WIDTH)) && word_sh[DAC_WIDTH-1];
      lrck_d  = right_slot ^ left_high;
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         div_q   <= '0;
         bck_q   <= 1'b0;
         b_q     <= LAST_BIT;
         lrck_q  <= 1'b0;
         din_q   <= 1'b0;
         fs_q    <= 1'b0;
         und_q   <= 1'b0;
         fmt_q   <= 2'd0;
         left_q  <= '0;
         right_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         div_q <= div_wrap ? '0 : div_q + DivW'(1);
         if (div_wrap) begin
            bck_q <= ~bck_q;
         end
         fs_q  <= frame_start;
         und_q <= frame_start && empty;
         if (fall) begin
            b_q    <= b_nxt;
            lrck_q <= lrck_d;
            din_q  <= din_d;
         end
         if (frame_start) begin
            fmt_q   <= fmt;
            left_q  <= load_l;
            right_q <= load_r;
         end
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ready_q <= ready_d;
      end
   end

   assign bck          = bck_q;
   assign lrck         = lrck_q;
   assign din          = din_q;
   assign frame_strobe = fs_q;
   assign underrun     = und_q;
   assign s.s_ready    = ready_q;
   assign fifo_level   = LW'(wptr_q - rptr_q);
endmodule
